// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snoop agent: cbus/mbus command codes,
// line states, agent FSM states and the fixed line-offset width.
package mesi_pkg;

    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WR_SNOOP = 3'd1,
        CMD_RD_SNOOP = 3'd2,
        CMD_EN_WR    = 3'd3,
        CMD_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [2:0] {
        MBUS_NOP      = 3'd0,
        MBUS_WR       = 3'd1,
        MBUS_RD       = 3'd2,
        MBUS_WR_BROAD = 3'd3,
        MBUS_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2,
        ST_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_LOOKUP,
        FSM_WB,
        FSM_ACK,
        FSM_WAIT_NOP
    } fsm_e;

endpackage

// File: rtl/mesi_line_table.sv
// Per-line tag and MESI state storage: one lookup read port, one write port,
// plus a state-only observation tap for the debug query.
module mesi_line_table
    import mesi_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output mesi_e                 o_rd_state,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  mesi_e                 i_wr_state,
    input  logic [INDEX_BITS-1:0] i_dbg_idx,
    output mesi_e                 o_dbg_state
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0] r_tag   [LINES];
    mesi_e               r_state [LINES];

    // NOTE: the array is small flops, so every entry is cleared on reset; reset
    // has priority so an in-flight write is dropped when rst and i_wr_en coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]   <= '0;
                r_state[i] <= ST_I;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_state[i_wr_idx] <= i_wr_state;
        end
    end

    assign o_rd_tag    = r_tag[i_rd_idx];
    assign o_rd_state  = r_state[i_rd_idx];
    assign o_dbg_state = r_state[i_dbg_idx];

endmodule

// File: rtl/mesi_snoop_agent.sv
// MESI snoop agent: executes one cbus coherence command at a time against the
// line table, writing dirty lines back to memory before they lose ownership.
module mesi_snoop_agent
    import mesi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
    output logic                  cbus_ack_o,
    output logic                  wb_req_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  wb_ack_i,
    input  logic [INDEX_BITS-1:0] dbg_idx_i,
    output logic [1:0]            dbg_state_o
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    fsm_e                  r_fsm;
    logic [2:0]            r_cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ack;
    logic                  r_wb_req;
    logic [ADDR_WIDTH-1:0] r_wb_addr;
    logic [TAG_BITS-1:0]   r_pend_tag;
    mesi_e                 r_pend_state;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [TAG_BITS-1:0]   w_rd_tag;
    mesi_e                 w_rd_state;
    mesi_e                 w_dbg_state;
    logic                  w_tag_match;
    logic                  w_hit;
    logic                  w_write;
    logic                  w_need_wb;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    logic [TAG_BITS-1:0]   w_next_tag;
    mesi_e                 w_next_state;
    logic                  w_wr_en;
    logic [TAG_BITS-1:0]   w_wr_tag;
    mesi_e                 w_wr_state;

    assign w_idx = r_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_tag = r_addr[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS];

    mesi_line_table #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_tag   (w_rd_tag),
        .o_rd_state (w_rd_state),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_state (w_wr_state),
        .i_dbg_idx  (dbg_idx_i),
        .o_dbg_state(w_dbg_state)
    );

    // Lookup decision: what the command does to the addressed line.
    always_comb begin
        w_tag_match  = (w_rd_tag == w_tag);
        w_hit        = (w_rd_state != ST_I) && w_tag_match;
        w_write      = 1'b0;
        w_need_wb    = 1'b0;
        w_wb_addr    = r_addr & ~OFFSET_MASK;
        w_next_tag   = w_rd_tag;
        w_next_state = w_rd_state;
        case (r_cmd)
            CMD_WR_SNOOP: begin
                if (w_hit) begin
                    w_write      = 1'b1;
                    w_need_wb    = (w_rd_state == ST_M);
                    w_next_state = ST_I;
                end
            end
            CMD_RD_SNOOP: begin
                if (w_hit && (w_rd_state == ST_M || w_rd_state == ST_E)) begin
                    w_write      = 1'b1;
                    w_need_wb    = (w_rd_state == ST_M);
                    w_next_state = ST_S;
                end
            end
            CMD_EN_WR, CMD_EN_RD: begin
                w_write      = 1'b1;
                w_need_wb    = !w_tag_match && (w_rd_state == ST_M);
                w_wb_addr    = {w_rd_tag, w_idx, {OFFSET_BITS{1'b0}}};
                w_next_tag   = w_tag;
                w_next_state = (r_cmd == CMD_EN_WR) ? ST_M : ST_S;
            end
            default: ;
        endcase
    end

    // Writes without a write-back commit at the end of LOOKUP; others on wb_ack_i.
    assign w_wr_en    = ((r_fsm == FSM_LOOKUP) && w_write && !w_need_wb)
                     || ((r_fsm == FSM_WB) && wb_ack_i);
    assign w_wr_tag   = (r_fsm == FSM_WB) ? r_pend_tag   : w_next_tag;
    assign w_wr_state = (r_fsm == FSM_WB) ? r_pend_state : w_next_state;

    // NOTE: r_ack defaults low each cycle and only the entry into ACK raises it;
    // with non-blocking assignments the later assignment in the same block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= FSM_IDLE;
            r_cmd        <= CMD_NOP;
            r_addr       <= '0;
            r_ack        <= 1'b0;
            r_wb_req     <= 1'b0;
            r_wb_addr    <= '0;
            r_pend_tag   <= '0;
            r_pend_state <= ST_I;
        end else begin
            r_ack <= 1'b0;
            case (r_fsm)
                FSM_IDLE: begin
                    if (cbus_cmd_i != CMD_NOP) begin
                        r_cmd  <= cbus_cmd_i;
                        r_addr <= cbus_addr_i;
                        r_fsm  <= FSM_LOOKUP;
                    end
                end
                FSM_LOOKUP: begin
                    if (w_need_wb) begin
                        r_wb_req     <= 1'b1;
                        r_wb_addr    <= w_wb_addr;
                        r_pend_tag   <= w_next_tag;
                        r_pend_state <= w_next_state;
                        r_fsm        <= FSM_WB;
                    end else begin
                        r_ack <= 1'b1;
                        r_fsm <= FSM_ACK;
                    end
                end
                FSM_WB: begin
                    if (wb_ack_i) begin
                        r_wb_req <= 1'b0;
                        r_ack    <= 1'b1;
                        r_fsm    <= FSM_ACK;
                    end
                end
                FSM_ACK:      r_fsm <= FSM_WAIT_NOP;
                FSM_WAIT_NOP: if (cbus_cmd_i == CMD_NOP) r_fsm <= FSM_IDLE;
                default:      r_fsm <= FSM_IDLE;
            endcase
        end
    end

    assign cbus_ack_o  = r_ack;
    assign wb_req_o    = r_wb_req;
    assign wb_addr_o   = r_wb_addr;
    assign dbg_state_o = w_dbg_state;

endmodule

// File: tb/tb_mesi_snoop_agent.sv
// Self-checking bench for mesi_snoop_agent: directed scenarios plus random
// command streams checked against a line-level MESI model.
module tb_mesi_snoop_agent;
    import mesi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cbus_cmd_i;
    logic [31:0] cbus_addr_i;
    logic        cbus_ack_o;
    logic        wb_req_o;
    logic [31:0] wb_addr_o;
    logic        wb_ack_i;
    logic [2:0]  dbg_idx_i;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Model of the cache lines: tag and MESI state per index.
    logic [24:0] m_tag   [8];
    logic [1:0]  m_state [8];

    always #5 clk = ~clk;

    mesi_snoop_agent #(.ADDR_WIDTH(32), .INDEX_BITS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cbus_cmd_i (cbus_cmd_i),
        .cbus_addr_i(cbus_addr_i),
        .cbus_ack_o (cbus_ack_o),
        .wb_req_o   (wb_req_o),
        .wb_addr_o  (wb_addr_o),
        .wb_ack_i   (wb_ack_i),
        .dbg_idx_i  (dbg_idx_i),
        .dbg_state_o(dbg_state_o)
    );

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i]   = '0;
            m_state[i] = 2'd0;
        end
    endfunction

    // Applies one command to the model; reports whether memory sees a write-back.
    function automatic void model_step(input logic [2:0] cmd, input logic [31:0] addr,
                                       output bit wb, output logic [31:0] wb_addr);
        int          idx;
        logic [24:0] tag;
        logic [1:0]  st;
        bit          hit;
        idx     = int'(addr[6:4]);
        tag     = addr[31:7];
        st      = m_state[idx];
        hit     = (st != 2'd0) && (m_tag[idx] == tag);
        wb      = 1'b0;
        wb_addr = addr & 32'hFFFF_FFF0;
        if (cmd == 3'd1 && hit) begin
            wb = (st == 2'd3);
            m_state[idx] = 2'd0;
        end else if (cmd == 3'd2 && hit && st != 2'd1) begin
            wb = (st == 2'd3);
            m_state[idx] = 2'd1;
        end else if (cmd == 3'd3 || cmd == 3'd4) begin
            if (m_tag[idx] != tag && st == 2'd3) begin
                wb      = 1'b1;
                wb_addr = (32'(m_tag[idx]) << 7) | (32'(idx) << 4);
            end
            m_tag[idx]   = tag;
            m_state[idx] = (cmd == 3'd3) ? 2'd3 : 2'd1;
        end
    endfunction

    // Drives one command, holds it through ack, then returns to NOP.
    task automatic run_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                           input int wb_wait, input bit spurious);
        bit          exp_wb;
        logic [31:0] exp_wba;
        logic [1:0]  old_state;
        int          idx;
        idx       = int'(addr[6:4]);
        old_state = m_state[idx];
        model_step(cmd, addr, exp_wb, exp_wba);
        @(negedge clk);
        cbus_cmd_i  = cmd;
        cbus_addr_i = addr;
        dbg_idx_i   = addr[6:4];
        @(negedge clk);
        checks++;
        if (cbus_ack_o !== 1'b0 || wb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lookup_quiet cmd=%0d addr=%h: ack=%b wb_req=%b, expected 0/0", cmd, addr, cbus_ack_o, wb_req_o);
        end
        if (spurious) wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        if (exp_wb) begin
            checks++;
            if (wb_req_o !== 1'b1 || wb_addr_o !== exp_wba) begin
                errors++;
                $display("FAIL wb_start cmd=%0d addr=%h: req=%b wb_addr=%h, expected 1 %h", cmd, addr, wb_req_o, wb_addr_o, exp_wba);
            end
            for (int i = 0; i < wb_wait; i++) begin
                @(negedge clk);
                checks++;
                if (wb_req_o !== 1'b1 || wb_addr_o !== exp_wba || cbus_ack_o !== 1'b0 || dbg_state_o !== old_state) begin
                    errors++;
                    $display("FAIL wb_hold cmd=%0d addr=%h: req=%b wb_addr=%h ack=%b state=%0d, expected 1 %h 0 %0d",
                             cmd, addr, wb_req_o, wb_addr_o, cbus_ack_o, dbg_state_o, exp_wba, old_state);
                end
            end
            wb_ack_i = 1'b1;
            @(negedge clk);
            wb_ack_i = 1'b0;
        end else begin
            checks++;
            if (wb_req_o !== 1'b0) begin
                errors++;
                $display("FAIL no_wb cmd=%0d addr=%h: wb_req=%b expected 0", cmd, addr, wb_req_o);
            end
        end
        checks++;
        if (cbus_ack_o !== 1'b1 || wb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_latency cmd=%0d addr=%h: ack=%b wb_req=%b, expected 1/0", cmd, addr, cbus_ack_o, wb_req_o);
        end
        @(negedge clk);
        checks++;
        if (cbus_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_width cmd=%0d addr=%h: ack=%b expected 0", cmd, addr, cbus_ack_o);
        end
        cbus_cmd_i = CMD_NOP;
        @(negedge clk);
        checks++;
        if (dbg_state_o !== m_state[idx]) begin
            errors++;
            $display("FAIL line_state cmd=%0d addr=%h: state=%0d expected %0d", cmd, addr, dbg_state_o, m_state[idx]);
        end
    endtask

    task automatic sweep_lines(input string name);
        for (int i = 0; i < 8; i++) begin
            dbg_idx_i = 3'(i);
            #1;
            checks++;
            if (dbg_state_o !== m_state[i]) begin
                errors++;
                $display("FAIL %s idx=%0d: state=%0d expected %0d", name, i, dbg_state_o, m_state[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cbus_cmd_i = CMD_NOP; cbus_addr_i = '0; wb_ack_i = 1'b0; dbg_idx_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (cbus_ack_o !== 1'b0 || wb_req_o !== 1'b0 || wb_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b wb_req=%b wb_addr=%h, expected all 0", cbus_ack_o, wb_req_o, wb_addr_o);
        end
        sweep_lines("reset_line");
    endtask

    task automatic test_en_wr();
        run_cmd(CMD_EN_WR, 32'h0000_0010, 0, 1'b0);
        dbg_idx_i = 3'd1;
        #1;
        checks++;
        if (dbg_state_o !== 2'd3) begin
            errors++;
            $display("FAIL en_wr_state: state=%0d expected 3", dbg_state_o);
        end
    endtask

    task automatic test_rd_snoop_wb();
        run_cmd(CMD_RD_SNOOP, 32'h0000_0010, 3, 1'b0);
        run_cmd(CMD_RD_SNOOP, 32'h0000_0010, 0, 1'b0);
    endtask

    task automatic test_victim_wb();
        run_cmd(CMD_EN_WR, 32'h0000_0010, 0, 1'b0);
        run_cmd(CMD_EN_RD, 32'h0000_0090, 1, 1'b1);
        run_cmd(CMD_WR_SNOOP, 32'h0000_0010, 0, 1'b0);
        run_cmd(CMD_WR_SNOOP, 32'h0000_0090, 0, 1'b0);
    endtask

    task automatic test_unknown_cmd();
        run_cmd(CMD_EN_WR, 32'h0000_0030, 0, 1'b0);
        for (int c = 5; c < 8; c++) run_cmd(3'(c), 32'h0000_0030, 0, 1'b1);
    endtask

    task automatic test_hold_cmd();
        bit          wb;
        logic [31:0] wba;
        int          acks;
        acks = 0;
        run_cmd(CMD_EN_RD, 32'h0000_0010, 0, 1'b0);
        model_step(CMD_WR_SNOOP, 32'h0000_0010, wb, wba);
        @(negedge clk);
        cbus_cmd_i  = CMD_WR_SNOOP;
        cbus_addr_i = 32'h0000_0010;
        dbg_idx_i   = 3'd1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cbus_ack_o === 1'b1) acks++;
        end
        checks++;
        if (acks != 1 || wb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL held_cmd_acks: acks=%0d wb_req=%b, expected 1/0", acks, wb_req_o);
        end
        cbus_cmd_i = CMD_NOP;
        @(negedge clk);
        checks++;
        if (dbg_state_o !== m_state[1]) begin
            errors++;
            $display("FAIL held_cmd_state: state=%0d expected %0d", dbg_state_o, m_state[1]);
        end
        run_cmd(CMD_EN_WR, 32'h0000_0010, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [24:0] tags [4];
        logic [24:0] tag;
        logic [2:0]  idx;
        logic [3:0]  low;
        tags[0] = 25'h0; tags[1] = 25'h1; tags[2] = 25'h2; tags[3] = 25'h1F0F0F;
        for (int n = 0; n < 80; n++) begin
            tag = tags[$urandom_range(0, 3)];
            idx = 3'($urandom_range(0, 7));
            low = 4'($urandom_range(0, 15));
            run_cmd(3'($urandom_range(1, 7)), {tag, idx, low}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        sweep_lines("random_sweep");
    endtask

    task automatic test_rst_during_wb();
        run_cmd(CMD_EN_WR, 32'h0000_0020, 0, 1'b0);
        @(negedge clk);
        cbus_cmd_i  = CMD_RD_SNOOP;
        cbus_addr_i = 32'h0000_0020;
        dbg_idx_i   = 3'd2;
        repeat (2) @(negedge clk);
        checks++;
        if (wb_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_wb_entered: wb_req=%b expected 1", wb_req_o);
        end
        rst      = 1'b1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        wb_ack_i   = 1'b0;
        cbus_cmd_i = CMD_NOP;
        model_reset();
        checks++;
        if (wb_req_o !== 1'b0 || cbus_ack_o !== 1'b0 || wb_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_wb_outputs: wb_req=%b ack=%b wb_addr=%h, expected 0", wb_req_o, cbus_ack_o, wb_addr_o);
        end
        sweep_lines("rst_wb_line");
        @(negedge clk);
        checks++;
        if (cbus_ack_o !== 1'b0 || wb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_after: ack=%b wb_req=%b, expected 0", cbus_ack_o, wb_req_o);
        end
        run_cmd(CMD_EN_RD, 32'h0000_0120, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_en_wr();
        test_rd_snoop_wb();
        test_victim_wb();
        test_unknown_cmd();
        test_hold_cmd();
        test_random();
        test_rst_during_wb();
        sweep_lines("final_sweep");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_snoop_agent.md
MESI_SNOOP_AGENT -- requirements
Module: mesi_snoop_agent

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter INDEX_BITS, default 3, giving 8 lines; the offset is fixed at 4 bits (16-byte line); tag = addr[ADDR_WIDTH-1:INDEX_BITS+4].
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cbus_cmd_i, input, 3, coherence command from the intercache controller.
REQ-006 SHALL have port cbus_addr_i, input, ADDR_WIDTH, command address.
REQ-007 SHALL have port cbus_ack_o, output, 1, command-done pulse to the controller.
REQ-008 SHALL have port wb_req_o, output, 1, write-back request to memory.
REQ-009 SHALL have port wb_addr_o, output, ADDR_WIDTH, line-aligned write-back address.
REQ-010 SHALL have port wb_ack_i, input, 1, write-back accepted.
REQ-011 SHALL have port dbg_idx_i, input, INDEX_BITS, line select for the state query.
REQ-012 SHALL have port dbg_state_o, output, 2, combinational MESI state of line dbg_idx_i.

Function
REQ-013 SHALL decode commands NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4; values 5-7 SHALL be acked with no state change.
REQ-014 SHALL encode MESI states as I=0, S=1, E=2, M=3, and hold per line a valid tag and a state.
REQ-015 SHALL run the FSM IDLE -> LOOKUP -> (WB) -> ACK -> WAIT_NOP -> IDLE.
REQ-016 In IDLE, a non-NOP cbus_cmd_i SHALL latch the command and address and move to LOOKUP on the next edge.
REQ-017 LOOKUP SHALL last exactly one cycle and compute hit = (state != I) and (tag match).
REQ-018 WR_SNOOP with a hit in M SHALL write the line back, then set it to I; a hit in S or E SHALL set I without write-back; a miss SHALL change nothing.
REQ-019 RD_SNOOP with a hit in M SHALL write the line back, then set it to S; a hit in E SHALL set S; S and a miss SHALL stay unchanged.
REQ-020 EN_WR SHALL install the tag and set M; EN_RD SHALL install the tag and set S; a tag hit SHALL upgrade in place.
REQ-021 For EN_WR or EN_RD, a tag mismatch whose victim is in M SHALL first write back the victim at {victim_tag, index, 4'b0}.
REQ-022 In WB, wb_req_o and wb_addr_o SHALL stay high and stable until the cycle wb_ack_i=1; the state update SHALL commit on that edge.
REQ-023 cbus_ack_o SHALL be high for exactly one cycle in ACK; the minimum latency from command to ack is 2 cycles (IDLE edge, LOOKUP).
REQ-024 WAIT_NOP SHALL hold until cbus_cmd_i==NOP, so a command held after ack is never re-executed.
REQ-025 A new command arriving in any state other than IDLE SHALL be ignored until the FSM re-enters IDLE.
REQ-026 wb_ack_i outside WB SHALL be ignored.

Reset
REQ-027 rst SHALL set every line to I with tag 0, the FSM to IDLE, and cbus_ack_o, wb_req_o and wb_addr_o to 0 on the next edge.
REQ-028 rst during WB SHALL abort it: wb_req_o drops and the line state is not updated.

Structure
REQ-029 The cbus command codes, MESI state codes and FSM state enum SHALL live in shared package mesi_pkg, together with the mbus command codes (NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4).
REQ-030 The tag/state array SHALL be a sub-module mesi_line_table with one read port and one write port; the FSM stays in mesi_snoop_agent.

Verification
REQ-031 Reset, then read dbg_state_o for all 8 indices -> all read 0 (I); all outputs read 0.
REQ-032 EN_WR at 0x0000_0010, then hold cmd until ack -> ack 2 cycles after the command; dbg_idx=1 reads M (3); no wb_req_o.
REQ-033 Line 1 in M, then RD_SNOOP at 0x10 -> wb_req_o=1, wb_addr_o=0x10; hold wb_ack_i=0 for 3 cycles, then 1 -> ack next cycle; state reads S (1).
REQ-034 Line 1 in M with tag of 0x10, then EN_RD at 0x0000_0090 -> victim write-back at 0x10, then line 1 reads S holding the new tag.
REQ-035 Hold WR_SNOOP for 10 cycles after ack -> exactly one ack pulse; FSM stays in WAIT_NOP until cmd=NOP.
REQ-036 Assert rst during WB -> next cycle wb_req_o=0, cbus_ack_o=0, all lines read I.
